// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, FSM state encoding and defaults for the SPI mode-0 target.
//   SPI_BYTE_W        : bits per SPI frame byte
//   BIT_CNT_W         : width of the in-byte bit counter
//   state_t/IDLE/SHIFT: target FSM state encoding
//   DEFAULT_IDLE_BYTE : byte sent on MISO when nothing is queued
//   shift_in()        : MSB-first serial shift helper
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam int unsigned BIT_CNT_W  = 3;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  localparam logic [SPI_BYTE_W-1:0] DEFAULT_IDLE_BYTE = 8'hff;

  // Append one serial bit below the bits already collected (MSB arrives first).
  function automatic logic [SPI_BYTE_W-2:0] shift_in(input logic [SPI_BYTE_W-2:0] cur,
                                                     input logic bit_in);
    return {cur[SPI_BYTE_W-3:0], bit_in};
  endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for one asynchronous input bit.
//   clk    : destination clock
//   resetn : synchronous active-low reset; all flops load RESET_VAL
//   d      : asynchronous input
//   q      : synchronised output, SYNC_STAGES clk cycles behind d
// SYNC_STAGES must be 2 or more.
module sync_ff #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] stages;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stages <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      stages <= {stages[SYNC_STAGES-2:0], d};
    end
  end

  assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_target.sv
// spi_target: SPI mode-0 target with oversampled pins, byte receive port and
// one-byte transmit holding register.
//   clk, resetn          : system clock, synchronous active-low reset
//   spi_clk/cs/mosi      : SPI pins from the controller (asynchronous to clk)
//   spi_miso, spi_miso_oe: MISO data and its output enable (high while selected)
//   rx_data/valid/ready  : received-byte port, valid/ready handshake
//   tx_data/valid/ready  : transmit-byte port into the holding register
//   overrun, overrun_clr : sticky dropped-byte flag and its clear
//   busy                 : chip select asserted (synchronised)
// Optional build macro SPI_TARGET_ECHO_EN: with an empty holding register the
// previously received byte is sent instead of IDLE_BYTE.
// SCK high and low phases must each last at least SYNC_STAGES+2 clk cycles.
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned            SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0]  IDLE_BYTE   = DEFAULT_IDLE_BYTE
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  busy
);

  // ---------------------------------------------------------------------------
  // Pin synchronisers and SCK edge detection
  // ---------------------------------------------------------------------------
  logic sck_s, cs_s, mosi_s;
  logic sck_q;

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk    (clk),
    .resetn (resetn),
    .d      (spi_clk),
    .q      (sck_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk    (clk),
    .resetn (resetn),
    .d      (spi_cs),
    .q      (cs_s)
  );

  sync_ff #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (clk),
    .resetn (resetn),
    .d      (spi_mosi),
    .q      (mosi_s)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sck_q <= 1'b0;
    end else begin
      sck_q <= sck_s;
    end
  end

  logic sck_rise, sck_fall;
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t                 state;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [SPI_BYTE_W-2:0]  shift_rx;   // seven bits suffice: the eighth is mosi_s itself
  logic [SPI_BYTE_W-1:0]  shift_tx;
  logic [SPI_BYTE_W-1:0]  tx_hold;
  logic                   hold_full;

  logic                   selected;
  logic                   byte_done;
  logic                   reload;
  logic                   tx_load;
  logic                   rx_take;
  logic [SPI_BYTE_W-1:0]  rx_byte;
  logic [SPI_BYTE_W-1:0]  empty_byte;
  logic [SPI_BYTE_W-1:0]  reload_byte;

  assign selected  = (state == SHIFT) && !cs_s;
  assign byte_done = selected && sck_rise && (bit_cnt == BIT_CNT_W'(SPI_BYTE_W - 1));
  assign rx_byte   = {shift_rx, mosi_s};

  // shift_tx is refilled on frame start and on the SCK fall that ends a byte.
  assign reload = ((state == IDLE) && !cs_s) ||
                  (selected && sck_fall && (bit_cnt == '0));

  assign tx_load  = tx_valid && !hold_full;
  assign tx_ready = !hold_full;

  // A byte completing while the consumer is accepting the old one still lands.
  assign rx_take = !rx_valid || rx_ready;

`ifdef SPI_TARGET_ECHO_EN
  logic [SPI_BYTE_W-1:0] last_rx;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_rx <= '0;
    end else if (byte_done) begin
      last_rx <= rx_byte;
    end
  end

  assign empty_byte = last_rx;
`else
  assign empty_byte = IDLE_BYTE;
`endif

  // Reload sees the holding register as it was before any same-cycle load.
  assign reload_byte = hold_full ? tx_hold : empty_byte;

  // ---------------------------------------------------------------------------
  // Transmit holding register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_hold   <= '0;
      hold_full <= 1'b0;
    end else if (tx_load) begin
      tx_hold   <= tx_data;
      hold_full <= 1'b1;
    end else if (reload) begin
      hold_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM and shift registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shift_rx <= '0;
      shift_tx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cs_s) begin
            state    <= SHIFT;
            bit_cnt  <= '0;
            shift_tx <= reload_byte;
          end
        end
        SHIFT: begin
          if (cs_s) begin
            // Frame aborted or ended: partial rx bits and shift_tx are dropped.
            state   <= IDLE;
            bit_cnt <= '0;
          end else if (sck_rise) begin
            shift_rx <= shift_in(shift_rx, mosi_s);
            bit_cnt  <= bit_cnt + 1'b1;
          end else if (sck_fall) begin
            if (bit_cnt != '0) begin
              shift_tx <= {shift_tx[SPI_BYTE_W-2:0], 1'b0};
            end else begin
              shift_tx <= reload_byte;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive port and overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (byte_done && rx_take) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // Setting takes priority over a simultaneous clear.
      if (byte_done && !rx_take) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign spi_miso    = (state == SHIFT) ? shift_tx[SPI_BYTE_W-1] : 1'b1;
  assign spi_miso_oe = (state == SHIFT);
  assign busy        = (state == SHIFT);

endmodule

// File: tb/tb_spi_target.sv
// Directed self-checking bench for spi_target: acts as an SPI mode-0
// controller with 8-cycle SCK half-periods plus rx/tx port drivers.
module tb_spi_target;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       resetn;
  logic       spi_clk, spi_cs, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic       overrun, overrun_clr, busy;

  int n_checks = 0;
  int n_errors = 0;

  spi_target #(.SYNC_STAGES(2), .IDLE_BYTE(8'hff)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .spi_clk     (spi_clk),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clock n bits of mo out MSB first; returns the MISO bits seen at each rise
  // and the cycles from the last rise until rx_valid was seen (99 if never).
  task automatic spi_bits(input logic [7:0] mo, input int n,
                          output logic [7:0] mi, output int lat);
    mi  = '0;
    lat = 99;
    for (int i = 0; i < n; i++) begin
      spi_mosi = mo[7-i];
      wait_clks(HALF);
      mi = {mi[6:0], spi_miso};
      spi_clk = 1'b1;
      for (int k = 1; k <= HALF; k++) begin
        @(negedge clk);
        if (rx_valid && lat == 99) lat = k;
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic cs_high();
    wait_clks(HALF);
    spi_cs = 1'b1;
    wait_clks(HALF);
  endtask

  task automatic tx_push(input logic [7:0] b);
    bit done = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      if (tx_ready) done = 1'b1;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("tx_push_accepted", 32'(done), 32'd1);
  endtask

  task automatic pulse_rx_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    wait_clks(3);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  logic [7:0] mi, mi2;
  int         lat;

  initial begin
    spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0;
    rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0; overrun_clr = 1'b0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("rst_miso", 32'(spi_miso), 32'd1);
    check("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);

    // Single byte: queued A5 out, 3C in
    tx_push(8'ha5);
    check("t2_tx_ready_full", 32'(tx_ready), 32'd0);
    cs_low();
    check("t2_busy", 32'(busy), 32'd1);
    check("t2_miso_oe", 32'(spi_miso_oe), 32'd1);
    check("t2_tx_ready_empty", 32'(tx_ready), 32'd1);
    check("t2_first_bit", 32'(spi_miso), 32'd1);
    spi_bits(8'h3c, 8, mi, lat);
    check("t2_miso_byte", 32'(mi), 32'ha5);
    check("t2_rx_latency_ok", 32'(lat <= 4), 32'd1);
    check("t2_rx_data", 32'(rx_data), 32'h3c);
    check("t2_rx_valid", 32'(rx_valid), 32'd1);
    cs_high();
    check("t2_idle_oe", 32'(spi_miso_oe), 32'd0);
    check("t2_idle_miso", 32'(spi_miso), 32'd1);
    pulse_rx_ready();
    check("t2_rx_consumed", 32'(rx_valid), 32'd0);

    // Two bytes, consumer stalled, nothing queued -> overrun
    cs_low();
    spi_bits(8'h11, 8, mi, lat);
    spi_bits(8'h22, 8, mi2, lat);
    check("t3_miso_b0", 32'(mi), 32'hff);
    check("t3_miso_b1", 32'(mi2), 32'hff);
    check("t3_rx_data_kept", 32'(rx_data), 32'h11);
    check("t3_rx_valid", 32'(rx_valid), 32'd1);
    check("t3_overrun_set", 32'(overrun), 32'd1);
    cs_high();
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 32'd0);
    pulse_rx_ready();
    check("t3_rx_consumed", 32'(rx_valid), 32'd0);

    // Aborted partial byte, then a full 80
    cs_low();
    spi_bits(8'hff, 5, mi, lat);
    cs_high();
    check("t4_bit_cnt_reset", 32'(dut.bit_cnt), 32'd0);
    check("t4_partial_dropped", 32'(rx_valid), 32'd0);
    cs_low();
    spi_bits(8'h80, 8, mi, lat);
    check("t4_rx_data", 32'(rx_data), 32'h80);
    check("t4_rx_valid", 32'(rx_valid), 32'd1);
    cs_high();
    pulse_rx_ready();

    // Back-to-back transmit bytes 01, 02
    rx_ready = 1'b1;
    tx_push(8'h01);
    check("t5_tx_ready_full0", 32'(tx_ready), 32'd0);
    cs_low();
    tx_push(8'h02);
    check("t5_tx_ready_full1", 32'(tx_ready), 32'd0);
    spi_bits(8'haa, 8, mi, lat);
    spi_bits(8'h55, 8, mi2, lat);
    check("t5_miso_b0", 32'(mi), 32'h01);
    check("t5_miso_b1", 32'(mi2), 32'h02);
    cs_high();
    check("t5_tx_ready_end", 32'(tx_ready), 32'd1);
    check("t5_no_overrun", 32'(overrun), 32'd0);
    rx_ready = 1'b0;
    @(negedge clk);

    // Empty holding register: echo or idle byte
    do_reset();
    cs_low();
    spi_bits(8'h5a, 8, mi, lat);
    rx_ready = 1'b1;
    spi_bits(8'hc3, 8, mi2, lat);
    rx_ready = 1'b0;
    cs_high();
`ifdef SPI_TARGET_ECHO_EN
    check("t6_echo_b0", 32'(mi), 32'h00);
    check("t6_echo_b1", 32'(mi2), 32'h5a);
`else
    check("t6_idle_b0", 32'(mi), 32'hff);
    check("t6_idle_b1", 32'(mi2), 32'hff);
`endif
    check("t6_rx_data", 32'(rx_data), 32'hc3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 target (responder) for the integration SoC's SPI controller, i.e. the far end of its spi_clk/spi_cs/spi_mosi/spi_miso link.
- Oversamples the external SPI pins in the system clock domain.
- Deserialises MOSI bytes onto a valid/ready receive port and serialises queued bytes onto MISO.
- Used as an on-chip loopback partner for simulation and as a device model in FPGA bring-up.

Parameters:
- SYNC_STAGES, 2, flops per input synchroniser (spi_clk, spi_cs, spi_mosi); must be 2 or more.
- IDLE_BYTE, 8'hff, byte shifted out when no transmit byte is queued.

Ports:
- clk  input  1  system clock.
- resetn  input  1  synchronous active-low reset.
- spi_clk  input  1  SPI serial clock from the controller; asynchronous to clk.
- spi_cs  input  1  chip select, active-low.
- spi_mosi  input  1  controller-to-target data.
- spi_miso  output  1  target-to-controller data.
- spi_miso_oe  output  1  MISO output enable; 1 while CS is asserted.
- rx_data  output  8  last received byte.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready.
- tx_data  input  8  next byte to transmit.
- tx_valid  input  1  tx_data offered.
- tx_ready  output  1  transmit holding register empty.
- overrun  output  1  sticky: a received byte was dropped.
- overrun_clr  input  1  clears overrun.
- busy  output  1  CS asserted (synchronised).

Behaviour:
- Reset values (resetn low at posedge clk): rx_data=0, rx_valid=0, overrun=0, tx_ready=1 (holding register empty), spi_miso=1, spi_miso_oe=0, busy=0, bit_cnt=0, state=IDLE, all synchroniser flops = inactive levels (clk 0, cs 1, mosi 0).
- Inputs pass through SYNC_STAGES flops. Edges are detected on the synchronised spi_clk against its registered copy.
- Constraint: SPI clock high and low phases must each last at least SYNC_STAGES+2 clk cycles. Faster SCK is unsupported and unchecked.
- State machine (2 states):
  - IDLE: CS inactive. On synchronised CS falling: bit_cnt<=0; shift_tx <= holding full ? tx_hold : IDLE_BYTE; holding emptied; go to SHIFT.
  - SHIFT: on SCK rising: shift_rx <= {shift_rx[6:0], mosi_s}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7->0).
  - SHIFT, 8th rising edge (bit_cnt was 7): byte completes. If rx_valid=0, or rx_valid&&rx_ready in the same cycle, then rx_data <= {shift_rx[6:0], mosi_s} and rx_valid <= 1. Otherwise the new byte is dropped, rx_data is kept and overrun <= 1.
  - SHIFT, SCK falling: if bit_cnt!=0, shift_tx <= shift_tx<<1. If bit_cnt==0 (a byte just ended), reload shift_tx from holding (if full) or IDLE_BYTE, as on CS assertion.
  - CS rising (synchronised), any bit position: return to IDLE; partial rx byte discarded; bit_cnt<=0; shift_tx discarded, and any byte already moved into it counts as sent; tx_hold is untouched.
- MISO: spi_miso = shift_tx[7] in SHIFT, 1 in IDLE. spi_miso_oe = (state==SHIFT). The first bit is on MISO at least SYNC_STAGES+1 cycles after CS falls, before the first SCK rise.
- Transmit handshake: tx_ready = !holding_full. tx_valid&&tx_ready loads tx_hold the next cycle. If a load and a reload fall in the same cycle, the reload takes the old state (empty => IDLE_BYTE) and the new byte stays held.
- rx handshake: rx_valid falls the cycle after rx_valid&&rx_ready, unless a new byte completes that same cycle.
- overrun: set wins over overrun_clr in the same cycle.
- busy = (state==SHIFT).

Optional Feature:
- SPI_TARGET_ECHO_EN.
- Defined: when the holding register is empty at a reload, shift_tx <= last completed rx byte (0 after reset) instead of IDLE_BYTE, so the target echoes the previous byte one byte late.
- Undefined: IDLE_BYTE is sent. No other behaviour differs.

Decomposition:
- Package spi_pkg: SPI_BYTE_W=8, BIT_CNT_W=3, state enum {IDLE, SHIFT}, default IDLE_BYTE.
- Sub-module: sync_ff (parameterised SYNC_STAGES, 1-bit, reset value parameter), instantiated 3 times.
- Edge detect and both FSM actions stay in spi_target.

Test Plan:
- Reset hold of 3 cycles with CS high -> spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_valid=0, overrun=0.
- Queue tx 8'hA5, CS low, controller sends 8'h3C at 8-cycle half-periods -> controller samples 8'hA5 on MISO; rx_data=8'h3C, rx_valid=1 within SYNC_STAGES+2 cycles of the 8th rise.
- Two bytes 8'h11, 8'h22 with rx_ready=0, nothing queued -> rx_data=8'h11, overrun=1, MISO returns 8'hFF,8'hFF; overrun_clr then clears overrun.
- CS deasserted after 5 bits, then a full byte 8'h80 -> partial byte discarded; only 8'h80 delivered; bit_cnt restarts at 0.
- tx_valid held with 8'h01,8'h02 back-to-back over two bytes -> MISO sequence 8'h01,8'h02; tx_ready low while holding is full.
- With SPI_TARGET_ECHO_EN defined, send 8'h5A then 8'hC3 with nothing queued -> MISO returns 8'h00 then 8'h5A.
